// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Responder for the CPU data SRAM port. Accesses use single-cycle-latency
// synchronous semantics: address and enable are presented in one cycle, and
// read data is returned in the next cycle. Each access goes either to a
// word-addressed RAM bank with byte-lane writes, or to a small configuration
// page.
//
// Configuration page (addr[31:16] == CONF_BASE), decoded on addr[15:0]:
//   f000 LED     RW, bits 15:0 (upper bits read 0)
//   f004 NUM     RW, 32 bits
//   f008 SWITCH  RO, {24'b0, synchronized switches}
//   f00c TIMER   RW, free-running counter (only when DATA_SRAM_RESP_TIMER_EN
//                is defined; otherwise it reads 0 and ignores writes)
//   any other offset reads 0 and ignores writes
//
// Optional feature macro: DATA_SRAM_RESP_TIMER_EN
//
// Ports:
//   clk               clock
//   resetn            synchronous active-low reset
//   data_sram_en      access request this cycle
//   data_sram_wen     byte write enables (0 = read)
//   data_sram_addr    byte address; addr[1:0] ignored
//   data_sram_wdata   write data
//   data_sram_rdata   read data, one cycle after a read request
//   switch_in         board switches (asynchronous)
//   led_out           LED register
//   num_out           seven-segment number register
// -----------------------------------------------------------------------------
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf004;
  localparam logic [15:0] OFF_SWITCH = 16'hf008;
  localparam logic [15:0] OFF_TIMER  = 16'hf00c;
  localparam int          RAM_DEPTH  = 1 << RAM_AW;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Decode
  logic              conf_sel;
  logic              rd_req;
  logic              wr_req;
  logic [15:0]       conf_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsb;

  assign conf_sel        = (data_sram_addr[31:16] == CONF_BASE);
  assign conf_off        = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign rd_req          = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_req          = data_sram_en && (data_sram_wen != 4'b0000);
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // RAM bank: contents are not reset, but a write in a reset cycle is dropped.
  logic [31:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (resetn && wr_req && !conf_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registers
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] conf_rdata;

`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0] timer_q, timer_d;
`endif

  // Configuration-page read mux; reflects register values before this edge.
  always_comb begin
    conf_rdata = 32'h0;
    case (conf_off)
      OFF_LED:    conf_rdata = {16'h0, led_q};
      OFF_NUM:    conf_rdata = num_q;
      OFF_SWITCH: conf_rdata = {24'h0, sync2_q};
`ifdef DATA_SRAM_RESP_TIMER_EN
      OFF_TIMER:  conf_rdata = timer_q;
`endif
      default:    conf_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    led_d   = led_q;
    num_d   = num_q;
    if (rd_req) begin
      rdata_d = conf_sel ? conf_rdata : mem_q[ram_idx];
    end
    if (wr_req && conf_sel && (conf_off == OFF_LED)) begin
      led_d[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0];
      led_d[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8];
    end
    if (wr_req && conf_sel && (conf_off == OFF_NUM)) begin
      num_d = byte_merge(num_q, data_sram_wdata, data_sram_wen);
    end
  end

`ifdef DATA_SRAM_RESP_TIMER_EN
  // A write to the timer replaces that cycle's increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_req && conf_sel && (conf_off == OFF_TIMER)) begin
      timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      num_q   <= 32'h0;
      sync1_q <= 8'h0;
      sync2_q <= 8'h0;
`ifdef DATA_SRAM_RESP_TIMER_EN
      timer_q <= 32'h0;
`endif
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      num_q   <= num_d;
      sync1_q <= switch_in;
      sync2_q <= sync1_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;
  assign num_out         = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam logic [15:0] CONF_BASE = 16'hbfaf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [31:0] num;

  data_sram_responder #(.RAM_AW(14), .CONF_BASE(CONF_BASE)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .switch_in(sw), .led_out(led), .num_out(num)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata = 0;
  logic [15:0] m_led = 0;
  logic [31:0] m_num = 0;
  logic [31:0] m_timer = 0;
  logic [7:0]  m_s1 = 0, m_s2 = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, act, expv);
    end
  endtask

  // Monitor: compares DUT outputs after each edge against scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("led_out", {16'h0, led}, {16'h0, e.led});
        check("num_out", num, e.num);
      end
    end
  end

  // One bus cycle: drive inputs, advance the model, queue the expected outputs.
  task automatic cyc(input logic rn, input logic e, input logic [3:0] we,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rv;
    int          idx;
    logic        conf, tw;
    exp_t        x;
    @(negedge clk);
    resetn = rn; en = e; wen = we; addr = a; wdata = d;
    conf = (a[31:16] == CONF_BASE);
    idx  = int'(a[15:2]);
    rv   = 32'h0;
    tw   = 1'b0;
    if (conf) begin
      case (a[15:0])
        16'hf000: rv = {16'h0, m_led};
        16'hf004: rv = m_num;
        16'hf008: rv = {24'h0, m_s2};
`ifdef DATA_SRAM_RESP_TIMER_EN
        16'hf00c: rv = m_timer;
`endif
        default:  rv = 32'h0;
      endcase
    end else begin
      rv = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
    end
    if (!rn) begin
      m_rdata = 0; m_led = 0; m_num = 0; m_timer = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (e && we == 4'h0) m_rdata = rv;
      if (e && we != 4'h0) begin
        if (conf) begin
          case (a[15:0])
            16'hf000: m_led = merge({16'h0, m_led}, d, we & 4'b0011) & 32'hffff;
            16'hf004: m_num = merge(m_num, d, we);
`ifdef DATA_SRAM_RESP_TIMER_EN
            16'hf00c: begin m_timer = merge(m_timer, d, we); tw = 1'b1; end
`endif
            default: ;
          endcase
        end else begin
          m_mem[idx] = merge(m_mem.exists(idx) ? m_mem[idx] : 32'h0, d, we);
        end
      end
      if (!tw) m_timer = m_timer + 1;
      m_s2 = m_s1;
      m_s1 = sw;
    end
    x.cyc = edge_cnt + 1; x.rdata = m_rdata; x.led = m_led; x.num = m_num;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [15:0] up;
    logic [3:0]  we;
    logic [15:0] offs [6];
    offs[0] = 16'hf000; offs[1] = 16'hf004; offs[2] = 16'hf008;
    offs[3] = 16'hf00c; offs[4] = 16'hf0f0; offs[5] = 16'h0124;
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;

    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Initialise the RAM words used below.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'hf, 32'(i * 4), $urandom);

    // Full word then partial byte-lane write, each read back.
    cyc(1'b1, 1'b1, 4'hf, 32'h0000_0010, 32'hdeadbeef);
    cyc(1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    cyc(1'b1, 1'b1, 4'b0101, 32'h0000_0010, 32'h11223344);
    cyc(1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    idle();

    // Configuration registers.
    cyc(1'b1, 1'b1, 4'hf, 32'hbfaf_f000, 32'h1234abcd);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
    cyc(1'b1, 1'b1, 4'hf, 32'hbfaf_f004, 32'h87654321);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f004, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f0f0, 32'h0);

    // Switch synchroniser; write to the read-only register is ignored.
    sw = 8'h5a;
    idle(); idle(); idle();
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f008, 32'h0);
    cyc(1'b1, 1'b1, 4'hf, 32'hbfaf_f008, 32'hffffffff);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f008, 32'h0);

    // Timer write and wrap.
    cyc(1'b1, 1'b1, 4'hf, 32'hbfaf_f00c, 32'hffff_fffe);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f00c, 32'h0);
    idle();
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f00c, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 32'hbfaf_f00c, 32'h0);

    // Reset in the same cycle as a RAM write: the write must be dropped.
    cyc(1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
    cyc(1'b0, 1'b1, 4'hf, 32'h0000_0020, 32'hcafef00d);
    cyc(1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
    idle();

    // Randomised traffic with address aliasing and occasional reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = {CONF_BASE, offs[$urandom_range(0, 5)]};
      end else begin
        up = 16'($urandom);
        if (up == CONF_BASE) up = 16'h0;
        a = {up, 10'h0, 4'($urandom), 2'($urandom)};
      end
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), we, a, d);
    end

    idle(); idle(); idle();
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
